// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder with error checking.
// Serves word reads and byte-masked writes from an internal RAM of DEPTH words.
module dmem_responder #(
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic [3:0]  d_be_i,
    input  logic        d_rd_i,
    input  logic        d_wr_i,
    output logic [31:0] d_data_o,
    output logic        d_rdy_o,
    output logic        d_err_o,
    output logic        d_busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [32:0] DEPTH_W = 33'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic        rdy_q, rdy_d, err_q, err_d, busy_q, busy_d;
    logic [31:0] mem [DEPTH];

    logic          idle, req, go, bad, we, r, w;
    logic [31:0]   a, wd;
    logic [3:0]    b;
    logic [AW-1:0] idx;

    always_comb begin
        idle    = state_q == IDLE;
        // With no wait states the access happens on the capture edge, so use the live inputs
        a       = idle ? d_addr_i : addr_q;
        wd      = idle ? d_data_i : wdata_q;
        b       = idle ? d_be_i : be_q;
        r       = idle ? d_rd_i : rd_q;
        w       = idle ? d_wr_i : wr_q;
        idx     = a[AW+1:2];
        req     = idle && (d_rd_i || d_wr_i);
        go      = (req && WAIT_STATES == 0) || (state_q == WAIT && cnt_q == 4'd1);
        bad     = (a[1:0] != 2'b00) || ({3'b000, a[31:2]} >= DEPTH_W) || (r && w);
        we      = go && w && !bad;
        state_d = go ? RESP : req ? WAIT : state_q == RESP ? IDLE : state_q;
        cnt_d   = (req && !go) ? 4'(WAIT_STATES) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
        addr_d  = req ? d_addr_i : addr_q;
        wdata_d = req ? d_data_i : wdata_q;
        be_d    = req ? d_be_i : be_q;
        rd_d    = req ? d_rd_i : rd_q;
        wr_d    = req ? d_wr_i : wr_q;
        rdy_d   = go;
        err_d   = go && bad;
        rdata_d = (go && r && !bad) ? mem[idx] : 32'h0;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // RAM has no reset; gating with rst_n_i keeps an aborted write from landing
    always_ff @(posedge clk_i) begin
        if (we && rst_n_i)
            for (int i = 0; i < 4; i++)
                if (b[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end

    assign d_data_o = rdata_q;
    assign d_rdy_o  = rdy_q;
    assign d_err_o  = err_q;
    assign d_busy_o = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven and scoreboard checks of dmem_responder
// with a zero-wait instance (index 0) and a three-wait instance (index 1).
module tb_dmem_responder;
    typedef struct {
        int          u;
        logic        rd, wr;
        logic [31:0] a, d;
        logic [3:0]  be;
        logic [31:0] xd;
        logic        xe;
    } vec_t;
    typedef struct {
        int          u;
        logic [31:0] xd;
        logic        xe;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        rd[2], wr[2], rdy[2], err[2], busy[2];
    logic [31:0] addr[2], wdata[2], rdata[2];
    logic [3:0]  be[2];

    exp_t        sb[$];
    logic [31:0] model[2][32];
    vec_t        tv[21];
    int          nvec = 0, nerr = 0, cyc = 0, last_rdy = 0;
    bit          gap_on = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_responder #(.DEPTH(32), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_n_i(rst_n), .d_addr_i(addr[0]), .d_data_i(wdata[0]), .d_be_i(be[0]),
        .d_rd_i(rd[0]), .d_wr_i(wr[0]), .d_data_o(rdata[0]), .d_rdy_o(rdy[0]),
        .d_err_o(err[0]), .d_busy_o(busy[0]));
    dmem_responder #(.DEPTH(32), .WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_n_i(rst_n), .d_addr_i(addr[1]), .d_data_i(wdata[1]), .d_be_i(be[1]),
        .d_rd_i(rd[1]), .d_wr_i(wr[1]), .d_data_o(rdata[1]), .d_rdy_o(rdy[1]),
        .d_err_o(err[1]), .d_busy_o(busy[1]));

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every ready pulse pops one expected response
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (err[u] && !rdy[u]) chk($sformatf("err_without_rdy u%0d", u), 32'(err[u]), 32'(rdy[u]));
            if (rdy[u]) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_rdy u%0d: got rdy=1 want 0", u);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("rdy_unit t=%0t", $time), 32'(u), 32'(e.u));
                    chk($sformatf("rdata u%0d t=%0t", u, $time), rdata[u], e.xd);
                    chk($sformatf("err u%0d t=%0t", u, $time), 32'(err[u]), 32'(e.xe));
                end
                if (u == 1 && gap_on) begin
                    if (last_rdy != 0) chk("rdy_spacing", 32'(cyc - last_rdy), 32'd5);
                    last_rdy = cyc;
                end
            end
        end
    end

    task automatic xact(int u, logic r, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] b,
                        logic [31:0] xd, logic xe);
        int n;
        @(negedge clk);
        rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d; be[u] = b;
        sb.push_back('{u, xd, xe});
        if (w && !r && !xe)
            for (int i = 0; i < 4; i++)
                if (b[i]) model[u][a[6:2]][8*i +: 8] = d[8*i +: 8];
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[u] && n < 30);
        chk($sformatf("latency u%0d a=%h", u, a), 32'(n), u == 1 ? 32'd4 : 32'd1);
        rd[u] = 0; wr[u] = 0;
    endtask

    task automatic chk_zero(int u, string tag);
        chk($sformatf("%s data u%0d", tag, u), rdata[u], 32'h0);
        chk($sformatf("%s rdy u%0d", tag, u), 32'(rdy[u]), 32'h0);
        chk($sformatf("%s err u%0d", tag, u), 32'(err[u]), 32'h0);
        chk($sformatf("%s busy u%0d", tag, u), 32'(busy[u]), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, x;
        tv[0]  = '{0, 1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        tv[1]  = '{0, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        tv[2]  = '{0, 1'b0, 1'b1, 32'h08, 32'h000000AA, 4'h1, 32'h0, 1'b0};
        tv[3]  = '{0, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0};
        tv[4]  = '{0, 1'b0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
        tv[5]  = '{0, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0};
        tv[6]  = '{0, 1'b0, 1'b1, 32'h08, 32'h11223344, 4'h6, 32'h0, 1'b0};
        tv[7]  = '{0, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 32'hDE2233AA, 1'b0};
        tv[8]  = '{0, 1'b1, 1'b0, 32'h06, 32'h0, 4'h0, 32'h0, 1'b1};
        tv[9]  = '{0, 1'b0, 1'b1, 32'h00, 32'h0A0B0C0D, 4'hF, 32'h0, 1'b0};
        tv[10] = '{0, 1'b0, 1'b1, 32'h80, 32'h55555555, 4'hF, 32'h0, 1'b1};
        tv[11] = '{0, 1'b1, 1'b0, 32'h00, 32'h0, 4'h0, 32'h0A0B0C0D, 1'b0};
        tv[12] = '{0, 1'b0, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
        tv[13] = '{0, 1'b1, 1'b1, 32'h0C, 32'h0, 4'hF, 32'h0, 1'b1};
        tv[14] = '{0, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0};
        tv[15] = '{0, 1'b1, 1'b0, 32'h10000008, 32'h0, 4'h0, 32'h0, 1'b1};
        tv[16] = '{1, 1'b0, 1'b1, 32'h04, 32'h13579BDF, 4'hF, 32'h0, 1'b0};
        tv[17] = '{1, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 32'h13579BDF, 1'b0};
        tv[18] = '{1, 1'b1, 1'b0, 32'h07, 32'h0, 4'h0, 32'h0, 1'b1};
        tv[19] = '{1, 1'b0, 1'b1, 32'h84, 32'h55555555, 4'hF, 32'h0, 1'b1};
        tv[20] = '{1, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 32'h13579BDF, 1'b0};

        for (int u = 0; u < 2; u++) begin
            rd[u] = 0; wr[u] = 0; addr[u] = 0; wdata[u] = 0; be[u] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(0, "reset");
        chk_zero(1, "reset");
        rst_n = 1;

        for (int i = 0; i < 32; i++) xact(1, 1'b0, 1'b1, 32'(i) << 2, $urandom, 4'hF, 32'h0, 1'b0);

        gap_on = 1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                a = 32'($urandom_range(0, 31)) << 2;
                xact(1, 1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), 32'h0, 1'b0);
            end else begin
                xact(1, 1'b1, 1'b0, a, 32'h0, 4'h0, model[1][a[6:2]], 1'b0);
            end
        end
        gap_on = 0;

        for (int i = 0; i < 21; i++)
            xact(tv[i].u, tv[i].rd, tv[i].wr, tv[i].a, tv[i].d, tv[i].be, tv[i].xd, tv[i].xe);

        // Held read: no recapture until the IDLE cycle after the ready pulse
        @(negedge clk);
        rd[1] = 1; addr[1] = 32'h04;
        x = model[1][1];
        sb.push_back('{1, x, 1'b0});
        sb.push_back('{1, x, 1'b0});
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            chk($sformatf("held busy c%0d", n), 32'(busy[1]), 32'((n <= 4) || (n >= 6 && n <= 9)));
            chk($sformatf("held rdy c%0d", n), 32'(rdy[1]), 32'(n == 4 || n == 9));
            if (n == 6) rd[1] = 0;
        end

        // Reset during the wait phase of a write aborts it
        @(negedge clk);
        wr[1] = 1; addr[1] = 32'h10; wdata[1] = 32'h12345678; be[1] = 4'hF;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1 chk_zero(1, "mid_reset");
        wr[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        xact(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, model[1][4], 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the nano_rv32i data port. It sits on the far end of the core's `d_*` interface and serves word reads and byte-masked writes from an internal RAM of `DEPTH` words. It inserts a configurable number of wait states and signals completion with a one-cycle ready pulse. It flags misaligned, out-of-range and conflicting requests with an error pulse instead of performing the access.

## Interface
- `DEPTH`, 32: RAM size in 32-bit words, power of two, ≥ 2.
- `WAIT_STATES`, 0: extra cycles between request capture and response, 0..15.
- `clk_i`  in  1: single clock, rising edge.
- `rst_n_i`  in  1: reset, asynchronous and active-low.
- `d_addr_i`  in  32: byte address from the core.
- `d_data_i`  in  32: write data from the core.
- `d_be_i`  in  4: byte enables for writes; bit n covers `d_data_i[8n+7:8n]`.
- `d_rd_i`  in  1: read request.
- `d_wr_i`  in  1: write request.
- `d_data_o`  out  32: read data, valid only while `d_rdy_o`=1.
- `d_rdy_o`  out  1: one-cycle completion pulse.
- `d_err_o`  out  1: one-cycle error pulse, coincident with `d_rdy_o`.
- `d_busy_o`  out  1: high while a request is in flight (WAIT or RESP).

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE → capture.** A rising edge in IDLE with `d_rd_i|d_wr_i`=1 captures addr, data, be and op into internal registers.
  - If `WAIT_STATES`=0, the FSM goes to RESP.
  - Otherwise it goes to WAIT with the counter loaded to `WAIT_STATES`.
- **WAIT.** The counter decrements each edge. When the counter is 1 at an edge, the FSM goes to RESP. Request inputs are ignored in WAIT and RESP.
- **Access.** The access happens on the edge that enters RESP.
  - Write: each byte with its `be` bit set is written to `mem[addr[31:2]]`.
  - Read: `mem[addr[31:2]]` is registered into `d_data_o`.
- **RESP.** `d_rdy_o`=1 for exactly one cycle, then the FSM returns to IDLE unconditionally. A request present in that IDLE cycle is captured on the following edge.
- **Error conditions.** These are evaluated on the captured request:
  - `addr[1:0]`≠0
  - `addr[31:2]` ≥ `DEPTH`
  - rd and wr both set
- **Error behaviour.** On error: no RAM write, `d_data_o`=0, `d_err_o`=1 alongside `d_rdy_o`. The error still consumes the full wait-state latency.
- **Write with `be`=0000.** Completes without error and changes nothing.
- **Write response.** `d_data_o`=0 on writes.
- **Read-after-write** to the same word returns the new data; back-to-back requests are naturally separated by the IDLE cycle.
- **Address width.** Only `addr[log2(DEPTH)+1:2]` indexes the RAM. Upper bits feed only the range check, so there is no aliasing or wrap-around.

## Timing
- Request sampled in cycle 0 → `d_rdy_o` high in cycle 1+`WAIT_STATES`.
- Throughput: one request per 2+`WAIT_STATES` cycles.
- The core holds `d_rd_i`/`d_wr_i` until it sees `d_rdy_o`, then deasserts them or presents the next request. Because requests are sampled only in IDLE, a held request is never double-captured.
- All outputs are registered. `d_busy_o` is decoded from registered state (high in WAIT and RESP).
- Reset values: `d_data_o`=0, `d_rdy_o`=0, `d_err_o`=0, `d_busy_o`=0, state=IDLE, counter=0.
- RAM contents are not reset.
- Reset asserted mid-request: the transaction is aborted immediately and no ready pulse is issued. A write is not performed if reset asserts before the RESP-entry edge.

## Test plan
- **Zero-wait write then read.** `WAIT_STATES`=0, write 0xDEADBEEF to 0x08 with be=1111, then read 0x08 → `d_rdy_o` in cycle 1 each time; read returns 0xDEADBEEF with `d_err_o`=0.
- **Partial-byte write.** After the above, write 0x000000AA to 0x08 with be=0001, then read → 0xDEADBEAA. Write with be=0000 → data unchanged, no error.
- **Wait states and busy.** `WAIT_STATES`=3, read 0x04 held high → `d_busy_o` high in cycles 1–4, `d_rdy_o` only in cycle 4. No second capture while the request is held; the next capture happens in IDLE cycle 5.
- **Error cases.**
  - Read at 0x06 (misaligned) → `d_rdy_o`=`d_err_o`=1, `d_data_o`=0.
  - Write at 0x80 with `DEPTH`=32 → error, RAM unchanged.
  - rd and wr both set → error, no write.
- **Reset mid-write.** `WAIT_STATES`=3, write 0x12345678 to 0x10, drop `rst_n_i` in cycle 2 → all outputs 0 immediately, no `d_rdy_o`; a later read of 0x10 returns the prior value.
- **Back-to-back sequence.** Ten alternating writes/reads over addresses 0x00–0x7C with random be, compared against a scoreboard → every read matches, one rdy per request, spacing exactly 2+`WAIT_STATES` cycles.
